// File: rtl/cpu_ex_stage.sv
// Execute stage: single-cycle ALU ops and a multi-cycle radix-2 Booth
// multiplier behind a valid/ready handshake on both sides.
module cpu_ex_stage #(
    parameter int MD_WD = 16,
    parameter int MR_WD = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_ir,
    input  logic [31:0] id_a,
    input  logic [31:0] id_b,
    input  logic        id_mul_v_alu,
    input  logic        id_get_nor,
    input  logic [3:0]  id_aluc,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_ir,
    output logic [31:0] wb_c,
    output logic        busy
);

    localparam int CW = $clog2(MR_WD + 1);
    // One guard bit on the accumulator so subtracting the most negative
    // multiplicand cannot overflow.
    localparam int AW = MD_WD + 1;
    localparam int PW = AW + MR_WD;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    step_cnt;
    logic [AW-1:0]    acc, mcand, booth_sum, acc_nxt;
    logic [MR_WD-1:0] mplr, mplr_nxt;
    logic             q_m1, q_m1_nxt;
    logic             accept, last_step;
    logic [31:0]      alu_c, mul_c;
    logic [PW-1:0]    prod;

    assign id_ready  = (state == IDLE) || (state == DONE && wb_ready);
    assign accept    = id_valid && id_ready;
    assign last_step = (state == MUL) && (step_cnt == CW'(MR_WD - 1));
    assign wb_valid  = (state == DONE);
    assign busy      = (state == MUL);

    // ALU result; NOR overrides the aluc select
    always_comb begin
        alu_c = 32'd0;
        if (id_get_nor)              alu_c = ~(id_a | id_b);
        else if (id_aluc == 4'b0001) alu_c = id_a << id_b[4:0];
        else if (id_aluc == 4'b0010) alu_c = id_a ^ id_b;
    end

    // One Booth step: add/sub on the multiplier bit pair, then arithmetic shift right
    always_comb begin
        booth_sum = acc;
        case ({mplr[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        {acc_nxt, mplr_nxt, q_m1_nxt} = {booth_sum[AW-1], booth_sum, mplr};
        prod  = {acc_nxt, mplr_nxt};
        mul_c = {{(32 - PW){prod[PW-1]}}, prod};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = id_mul_v_alu ? MUL : DONE;
            MUL:     if (last_step) state_nxt = DONE;
            DONE:    if (wb_ready) state_nxt = accept ? (id_mul_v_alu ? MUL : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: capture on accept, iterate while multiplying
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ir    <= 32'd0;
            wb_c     <= 32'd0;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            q_m1     <= 1'b0;
        end else if (accept) begin
            wb_ir    <= id_ir;
            step_cnt <= '0;
            if (id_mul_v_alu) begin
                acc   <= '0;
                mcand <= {id_a[MD_WD-1], id_a[MD_WD-1:0]};
                mplr  <= id_b[MR_WD-1:0];
                q_m1  <= 1'b0;
            end else begin
                wb_c  <= alu_c;
            end
        end else if (state == MUL) begin
            step_cnt <= step_cnt + CW'(1);
            acc      <= acc_nxt;
            mplr     <= mplr_nxt;
            q_m1     <= q_m1_nxt;
            if (last_step) wb_c <= mul_c;
        end
    end

endmodule

// File: tb/tb_cpu_ex_stage.sv
// Directed bench for cpu_ex_stage: table-driven ALU and MUL vectors plus
// hand-written reset, backpressure and abort sequences.
module tb_cpu_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir, id_a, id_b;
    logic        id_mul_v_alu, id_get_nor;
    logic [3:0]  id_aluc;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_ir, wb_c;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    cpu_ex_stage #(.MD_WD(16), .MR_WD(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_ir(id_ir), .id_a(id_a), .id_b(id_b),
        .id_mul_v_alu(id_mul_v_alu), .id_get_nor(id_get_nor), .id_aluc(id_aluc),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_ir(wb_ir), .wb_c(wb_c), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir, a, b;
        logic        nor_op;
        logic [3:0]  aluc;
        logic [31:0] exp_c;
    } alu_vec_t;

    typedef struct {
        logic [31:0] ir, a, b;
        logic [31:0] exp_c;
    } mul_vec_t;

    alu_vec_t alu_tab[8];
    mul_vec_t mul_tab[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Accept one multiply, then count cycles until the result appears
    task automatic do_mul(input mul_vec_t v, input int idx);
        int n, bcnt;
        id_valid = 1'b1; id_mul_v_alu = 1'b1; id_get_nor = 1'b0; id_aluc = 4'd0;
        id_ir = v.ir; id_a = v.a; id_b = v.b;
        tick;
        id_valid = 1'b0;
        n = 0; bcnt = 0;
        while (!wb_valid && n < 20) begin
            if (busy) bcnt++;
            tick;
            n++;
        end
        chk($sformatf("mul%0d_latency", idx), 32'(n), 32'd9);
        chk($sformatf("mul%0d_busy_cycles", idx), 32'(bcnt), 32'd9);
        chk($sformatf("mul%0d_c", idx), wb_c, v.exp_c);
        chk($sformatf("mul%0d_ir", idx), wb_ir, v.ir);
    endtask

    initial begin
        logic stable, saw_valid;

        alu_tab[0] = '{32'hA000_0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 4'b0010, 32'hFFFF_FFFF};
        alu_tab[1] = '{32'hA000_0002, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 4'b0010, 32'h0000_0000};
        alu_tab[2] = '{32'hA000_0003, 32'h0000_0001, 32'd31,        1'b0, 4'b0001, 32'h8000_0000};
        alu_tab[3] = '{32'hA000_0004, 32'h0000_0005, 32'h0000_0003, 1'b0, 4'b1111, 32'h0000_0000};
        alu_tab[4] = '{32'hA000_0005, 32'h0000_FFFF, 32'h00FF_0000, 1'b1, 4'b0001, 32'hFF00_0000};
        alu_tab[5] = '{32'hA000_0006, 32'h1234_5678, 32'hFFFF_FFE4, 1'b0, 4'b0001, 32'h2345_6780};
        alu_tab[6] = '{32'hA000_0007, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 4'b0010, 32'h1234_A987};
        alu_tab[7] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 4'b0000, 32'h0000_0000};

        mul_tab[0] = '{32'hB000_0001, 32'h0000_0007, 32'h0000_0003, 32'h0000_0015};
        mul_tab[1] = '{32'hB000_0002, 32'h0000_8000, 32'h0000_0100, 32'h0080_0000};
        mul_tab[2] = '{32'hB000_0003, 32'h0000_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        mul_tab[3] = '{32'hB000_0004, 32'h1234_0005, 32'hFFFF_FE02, 32'h0000_000A};
        mul_tab[4] = '{32'hB000_0005, 32'h0000_7FFF, 32'h0000_00FF, 32'h007F_7F01};
        mul_tab[5] = '{32'hB000_0006, 32'h0000_0003, 32'h0000_01FF, 32'hFFFF_FFFD};
        mul_tab[6] = '{32'hB000_0007, 32'h0000_8000, 32'h0000_00FF, 32'hFF80_8000};

        // Reset with a valid entry presented: must be ignored
        rst_n = 1'b0; id_valid = 1'b1; id_mul_v_alu = 1'b0; id_get_nor = 1'b0;
        id_aluc = 4'b0010; id_ir = 32'hDEAD_BEEF; id_a = 32'h1; id_b = 32'h2;
        wb_ready = 1'b1;
        tick; tick;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_wb_c",     wb_c,              32'd0);
        chk("rst_wb_ir",    wb_ir,             32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        rst_n = 1'b1; id_valid = 1'b0;
        tick;
        chk("rst_no_accept", {31'd0, wb_valid}, 32'd0);

        // ALU ops back to back, one result per cycle
        for (int i = 0; i < 8; i++) begin
            id_valid = 1'b1; id_mul_v_alu = 1'b0;
            id_ir = alu_tab[i].ir; id_a = alu_tab[i].a; id_b = alu_tab[i].b;
            id_get_nor = alu_tab[i].nor_op; id_aluc = alu_tab[i].aluc;
            chk($sformatf("alu%0d_id_ready", i), {31'd0, id_ready}, 32'd1);
            tick;
            chk($sformatf("alu%0d_valid", i), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("alu%0d_c", i), wb_c, alu_tab[i].exp_c);
            chk($sformatf("alu%0d_ir", i), wb_ir, alu_tab[i].ir);
        end
        id_valid = 1'b0;
        tick;
        chk("alu_drain_idle", {31'd0, wb_valid}, 32'd0);

        // Multiplies; the first starts from IDLE, the rest straight from DONE
        for (int i = 0; i < 7; i++) do_mul(mul_tab[i], i);
        tick;
        chk("mul_drain_idle", {31'd0, wb_valid}, 32'd0);

        // Backpressure: result held while wb_ready=0, queued entry waits
        wb_ready = 1'b0;
        id_valid = 1'b1; id_mul_v_alu = 1'b0; id_get_nor = 1'b0; id_aluc = 4'b0010;
        id_ir = 32'h1111_1111; id_a = 32'hAAAA_0000; id_b = 32'h0000_AAAA;
        tick;
        id_ir = 32'h2222_2222; id_a = 32'h3; id_b = 32'h4; id_aluc = 4'b0001;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (id_ready !== 1'b0 || wb_valid !== 1'b1 ||
                wb_ir !== 32'h1111_1111 || wb_c !== 32'hAAAA_AAAA) stable = 1'b0;
            tick;
        end
        chk("bp_hold_stable", {31'd0, stable}, 32'd1);
        chk("bp_held_c", wb_c, 32'hAAAA_AAAA);
        wb_ready = 1'b1;
        #1;
        chk("bp_ready_release", {31'd0, id_ready}, 32'd1);
        tick;
        chk("bp_next_valid", {31'd0, wb_valid}, 32'd1);
        chk("bp_next_c", wb_c, 32'h0000_0030);
        chk("bp_next_ir", wb_ir, 32'h2222_2222);

        // Reset mid-multiply after 4 steps: discard and stay quiet
        id_valid = 1'b1; id_mul_v_alu = 1'b1; id_ir = 32'hC000_0001;
        id_a = 32'h7; id_b = 32'h3;
        tick;
        id_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, wb_valid}, 32'd0);
        chk("abort_id_ready", {31'd0, id_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (wb_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
            tick;
        end
        chk("abort_no_pulse", {31'd0, saw_valid}, 32'd0);
        id_valid = 1'b1; id_mul_v_alu = 1'b0; id_get_nor = 1'b0; id_aluc = 4'b0010;
        id_ir = 32'h3333_3333; id_a = 32'h5; id_b = 32'h3;
        tick;
        id_valid = 1'b0;
        chk("post_abort_valid", {31'd0, wb_valid}, 32'd1);
        chk("post_abort_c", wb_c, 32'h0000_0006);
        chk("post_abort_ir", wb_ir, 32'h3333_3333);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
